// File: rtl/stack_alu_pipe.sv
// stack_alu_pipe: single-issue signed ALU with a fixed, parameterised
// latency between accepting an operation and presenting its result.
// Operands are captured on accept; the result is held until the consumer
// takes it, and a new operation may be accepted on that same edge.
module stack_alu_pipe #(
  parameter int WIDTH    = 16,
  parameter int LATENCY  = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] c_q;
  logic             ovf_q;
  logic             outValid_q;

  logic signed [WIDTH:0] aExt;
  logic signed [WIDTH:0] bExt;
  logic signed [WIDTH:0] sum;
  logic [WIDTH-1:0]      c_d;
  logic                  ovf_d;
  logic                  accept;

  // A new operation can enter when idle, or when the held result is being
  // taken this cycle so the pipeline never inserts a bubble.
  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = enable && in_valid && in_ready;

  assign aExt = {a_q[WIDTH-1], a_q};
  assign bExt = {b_q[WIDTH-1], b_q};

  // One extra bit of headroom lets overflow be read off the top two bits.
  always_comb begin
    case (mode_q)
      2'b00:   sum = aExt;
      2'b01:   sum = aExt + bExt;
      2'b10:   sum = aExt - bExt;
      default: sum = bExt - aExt;
    endcase
  end

  assign ovf_d = sum[WIDTH] ^ sum[WIDTH-1];

  // The true sign lives in the extra bit, so it picks the clamp direction.
  always_comb begin
    c_d = sum[WIDTH-1:0];
    if (SATURATE && ovf_d) begin
      c_d = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  // Control FSM plus all registered outputs; enable low freezes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      a_q        <= '0;
      b_q        <= '0;
      mode_q     <= 2'b00;
      c_q        <= '0;
      ovf_q      <= 1'b0;
      outValid_q <= 1'b0;
    end else if (enable) begin
      if (accept) begin
        a_q        <= a;
        b_q        <= b;
        mode_q     <= mode;
        cnt_q      <= 4'(LATENCY - 1);
        c_q        <= a;
        ovf_q      <= 1'b0;
        outValid_q <= 1'b0;
        state_q    <= BUSY;
      end else begin
        case (state_q)
          BUSY: begin
            if (cnt_q == 4'd0) begin
              c_q        <= c_d;
              ovf_q      <= ovf_d;
              outValid_q <= 1'b1;
              state_q    <= DONE;
            end else begin
              cnt_q <= 4'(cnt_q - 4'd1);
            end
          end
          DONE: begin
            if (out_ready) begin
              outValid_q <= 1'b0;
              state_q    <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign c         = c_q;
  assign ovf       = ovf_q;
  assign out_valid = outValid_q;

endmodule

// File: tb/tb_stack_alu_pipe.sv
// Bench for stack_alu_pipe: two LATENCY=4 instances (wrap and saturate)
// share one stimulus stream, and a LATENCY=1 instance is streamed
// back-to-back. Expected results come from integer arithmetic.
module tb_stack_alu_pipe;

  localparam int LAT = 4;
  localparam int NSTREAM = 10;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [1:0]  mode;

  logic        inReadyA, outValidA, ovfA;
  logic [15:0] cA;
  logic        inReadyB, outValidB, ovfB;
  logic [15:0] cB;

  logic        cEnable, cInValid, cOutReady;
  logic [15:0] cInA, cInB;
  logic [1:0]  cMode;
  logic        cInReady, cOutValid, cOvf;
  logic [15:0] cC;

  int vectors;
  int miscompares;

  stack_alu_pipe #(.WIDTH(16), .LATENCY(LAT), .SATURATE(1'b0)) dutWrap (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid),
    .in_ready(inReadyA), .a(a), .b(b), .mode(mode), .out_valid(outValidA),
    .out_ready(out_ready), .c(cA), .ovf(ovfA)
  );

  stack_alu_pipe #(.WIDTH(16), .LATENCY(LAT), .SATURATE(1'b1)) dutSat (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid),
    .in_ready(inReadyB), .a(a), .b(b), .mode(mode), .out_valid(outValidB),
    .out_ready(out_ready), .c(cB), .ovf(ovfB)
  );

  stack_alu_pipe #(.WIDTH(16), .LATENCY(1), .SATURATE(1'b0)) dutFast (
    .clk(clk), .rst(rst), .enable(cEnable), .in_valid(cInValid),
    .in_ready(cInReady), .a(cInA), .b(cInB), .mode(cMode), .out_valid(cOutValid),
    .out_ready(cOutReady), .c(cC), .ovf(cOvf)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result as {ovf, c}, from ordinary signed integer arithmetic.
  function automatic logic [16:0] refCalc(input logic [15:0] x, input logic [15:0] y,
                                          input logic [1:0] m, input bit sat);
    int sx, sy, r;
    logic o;
    logic [15:0] res;
    sx = int'($signed(x));
    sy = int'($signed(y));
    case (m)
      2'b00:   r = sx;
      2'b01:   r = sx + sy;
      2'b10:   r = sx - sy;
      default: r = sy - sx;
    endcase
    o = (r > 32767) || (r < -32768);
    if (o && sat) res = (r > 0) ? 16'h7FFF : 16'h8000;
    else          res = r[15:0];
    return {o, res};
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Accept one operation on both LATENCY=4 instances, optionally freeze
  // enable for stallLen cycles before the stallAt-th post-accept edge, and
  // verify preview, latency and final result. The result is left pending.
  task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb,
                               input logic [1:0] tm, input int stallAt, input int stallLen);
    logic [16:0] expW, expS;
    expW = refCalc(ta, tb, tm, 1'b0);
    expS = refCalc(ta, tb, tm, 1'b1);
    a = ta; b = tb; mode = tm; in_valid = 1'b1; out_ready = 1'b1; enable = 1'b1;
    #1;
    checkOutput("inReadyBeforeAccept", 32'(inReadyA), 32'd1);
    step;
    in_valid = 1'b0; out_ready = 1'b0;
    a = 16'($urandom); b = 16'($urandom); mode = 2'($urandom);
    checkOutput("previewC", 32'(cA), 32'(ta));
    checkOutput("previewValid", 32'(outValidA), 32'd0);
    checkOutput("previewOvf", 32'(ovfA), 32'd0);
    for (int k = 1; k <= LAT; k++) begin
      if (k == stallAt) begin
        enable = 1'b0;
        repeat (stallLen) begin
          step;
          checkOutput("stallValid", 32'(outValidA), 32'd0);
          checkOutput("stallC", 32'(cA), 32'(ta));
        end
        enable = 1'b1;
      end
      step;
      if (k < LAT) begin
        checkOutput("busyValid", 32'(outValidA), 32'd0);
      end
    end
    checkOutput("doneValidWrap", 32'(outValidA), 32'd1);
    checkOutput("resultWrap", 32'(cA), 32'(expW[15:0]));
    checkOutput("ovfWrap", 32'(ovfA), 32'(expW[16]));
    checkOutput("doneValidSat", 32'(outValidB), 32'd1);
    checkOutput("resultSat", 32'(cB), 32'(expS[15:0]));
    checkOutput("ovfSat", 32'(ovfB), 32'(expS[16]));
    checkOutput("doneInReady", 32'(inReadyA), 32'd0);
  endtask

  // Stream operations through the LATENCY=1 instance with both handshakes
  // held high; results must come out in order, one every two cycles.
  task automatic streamFast;
    logic [15:0] sA [NSTREAM];
    logic [15:0] sB [NSTREAM];
    logic [1:0]  sM [NSTREAM];
    logic [16:0] expQ [$];
    logic [16:0] e;
    int idx, results, lastCyc;
    bit acceptNow;
    for (int i = 0; i < NSTREAM; i++) begin
      sA[i] = 16'($urandom); sB[i] = 16'($urandom); sM[i] = 2'($urandom);
    end
    idx = 0; results = 0; lastCyc = -1;
    cEnable = 1'b1; cOutReady = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (idx < NSTREAM) begin
        cInA = sA[idx]; cInB = sB[idx]; cMode = sM[idx]; cInValid = 1'b1;
      end else begin
        cInValid = 1'b0;
      end
      #1;
      acceptNow = cInReady && cInValid;
      if (acceptNow) begin
        expQ.push_back(refCalc(sA[idx], sB[idx], sM[idx], 1'b0));
        idx++;
      end
      step;
      if (cOutValid) begin
        if (expQ.size() == 0) begin
          checkOutput("streamUnexpected", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("streamC", 32'(cC), 32'(e[15:0]));
          checkOutput("streamOvf", 32'(cOvf), 32'(e[16]));
        end
        if (lastCyc >= 0) checkOutput("streamGap", 32'(cyc - lastCyc), 32'd2);
        lastCyc = cyc;
        results++;
      end
    end
    checkOutput("streamCount", 32'(results), 32'(NSTREAM));
    cInValid = 1'b0;
  endtask

  initial begin
    logic [15:0] holdC;
    logic        holdOvf;
    vectors = 0; miscompares = 0;
    rst = 1'b0; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; mode = 2'b00;
    cEnable = 1'b1; cInValid = 1'b0; cOutReady = 1'b0;
    cInA = '0; cInB = '0; cMode = 2'b00;

    repeat (3) step;
    checkOutput("resetC", 32'(cA), 32'd0);
    checkOutput("resetOvf", 32'(ovfA), 32'd0);
    checkOutput("resetValid", 32'(outValidA), 32'd0);
    checkOutput("resetInReady", 32'(inReadyA), 32'd1);
    rst = 1'b1;
    step;

    // Basic add, then a long consumer stall while the result is held.
    applyStimulus(16'd5, 16'd3, 2'b01, 0, 0);
    holdC = cA; holdOvf = ovfA;
    repeat (10) begin
      step;
      checkOutput("holdValid", 32'(outValidA), 32'd1);
      checkOutput("holdC", 32'(cA), 32'(holdC));
      checkOutput("holdOvf", 32'(ovfA), 32'(holdOvf));
      checkOutput("holdInReady", 32'(inReadyA), 32'd0);
    end

    // Back-to-back accept on the result handshake; then overflow corners.
    applyStimulus(16'd2, 16'd7, 2'b11, 0, 0);
    applyStimulus(16'h7FFF, 16'd1, 2'b01, 0, 0);
    applyStimulus(16'h8000, 16'd1, 2'b10, 0, 0);
    applyStimulus(16'h8000, 16'h8000, 2'b01, 0, 0);
    applyStimulus(16'h1234, 16'hFFFF, 2'b00, 0, 0);

    // Enable stalls mid-operation and on the final counting cycle.
    applyStimulus(16'd100, 16'd250, 2'b11, 2, 3);
    applyStimulus(16'hFFF0, 16'd20, 2'b10, LAT, 2);
    applyStimulus(16'd9, 16'd4, 2'b10, 1, 1);

    // Asynchronous reset mid-operation aborts the result.
    a = 16'd40; b = 16'd2; mode = 2'b01; in_valid = 1'b1; out_ready = 1'b1;
    step;
    in_valid = 1'b0; out_ready = 1'b0;
    step;
    step;
    #3;
    rst = 1'b0;
    #1;
    checkOutput("asyncResetC", 32'(cA), 32'd0);
    checkOutput("asyncResetValid", 32'(outValidA), 32'd0);
    step;
    step;
    rst = 1'b1;
    #1;
    checkOutput("postResetInReady", 32'(inReadyA), 32'd1);
    repeat (LAT + 2) begin
      step;
      checkOutput("abortNoResult", 32'(outValidA), 32'd0);
    end
    applyStimulus(16'd40, 16'd2, 2'b01, 0, 0);

    // Randomised operations with random stalls.
    for (int n = 0; n < 30; n++) begin
      int sAt;
      sAt = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, LAT)) : 0;
      applyStimulus(16'($urandom), 16'($urandom), 2'($urandom), sAt, int'($urandom_range(1, 3)));
    end

    // Drain the held result, then exercise the LATENCY=1 stream.
    out_ready = 1'b1;
    step;
    checkOutput("drainValid", 32'(outValidA), 32'd0);
    checkOutput("drainInReady", 32'(inReadyA), 32'd1);
    streamFast();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stack_alu_pipe.md
STACK_ALU_PIPE -- requirements
Module: stack_alu_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand/result width in bits, legal range 2..32.
REQ-002 The block SHALL have parameter LATENCY, default 4, meaning cycles from accept to result valid, legal range 1..15.
REQ-003 The block SHALL have parameter SATURATE, default 0, meaning 1 = clamp signed overflow and 0 = wrap.
REQ-004 Port clk  input  1  sole clock; all state SHALL update on the rising edge only.
REQ-005 Port rst  input  1  reset, asynchronous assert and active-low (0 = reset); deassertion is synchronous to clk.
REQ-006 Port enable  input  1  clock enable; when 0, all state SHALL hold, including counter, outputs and handshakes.
REQ-007 Port in_valid  input  1  operation request.
REQ-008 Port in_ready  output  1  block can accept an operation this cycle.
REQ-009 Port a  input  WIDTH  operand A, signed two's complement.
REQ-010 Port b  input  WIDTH  operand B, signed two's complement.
REQ-011 Port mode  input  2  operation select: 00 = A, 01 = A+B, 10 = A-B, 11 = B-A.
REQ-012 Port out_valid  output  1  c holds a final result.
REQ-013 Port out_ready  input  1  consumer accepts result.
REQ-014 Port c  output  WIDTH  result.
REQ-015 Port ovf  output  1  signed overflow occurred on the current result; qualified by out_valid.

Function
REQ-016 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-017 in_ready SHALL be 1 in IDLE, 1 in DONE when out_ready=1, and 0 otherwise (combinational from state and out_ready).
REQ-018 Accept SHALL occur when enable=1, in_valid=1 and in_ready=1; on accept, the block SHALL register a, b and mode, load the counter with LATENCY-1, set c <= a (preview), clear ovf and out_valid, and enter BUSY.
REQ-019 In BUSY with enable=1, the counter SHALL decrement each cycle; operands SHALL not be re-sampled.
REQ-020 On the BUSY cycle where counter=0, the block SHALL write the computed result to c, write the overflow status to ovf, set out_valid=1, and enter DONE.
REQ-021 Therefore out_valid SHALL rise exactly LATENCY enabled cycles after the accept edge; with LATENCY=1 it rises on the edge after accept.
REQ-022 Arithmetic SHALL be computed at WIDTH+1 bits with sign extension; ovf=1 when the two top bits of the WIDTH+1 result differ; mode 00 SHALL always give ovf=0.
REQ-023 With SATURATE=0, c SHALL be the low WIDTH bits of the result; with SATURATE=1 on overflow, c SHALL be +max (0111..1) for positive overflow and -max-1 (100..0) for negative overflow.
REQ-024 In DONE, c, ovf and out_valid SHALL hold until enable=1 and out_ready=1 (result handshake).
REQ-025 A result handshake without a same-cycle accept SHALL clear out_valid and enter IDLE; c and ovf SHALL keep their values.
REQ-026 A result handshake with a same-cycle accept SHALL follow REQ-018 (back-to-back); no idle cycle is inserted.
REQ-027 in_valid in BUSY SHALL be ignored; the request is not lost, since the source holds it until in_ready.
REQ-028 mode, a and b changing during BUSY SHALL have no effect on the result.
REQ-029 enable=0 on the counter=0 cycle SHALL delay completion until the next enable=1 cycle.

Reset
REQ-030 While rst=0, the block SHALL hold state=IDLE, counter=0, c=0, ovf=0 and out_valid=0, asynchronously and independent of enable.
REQ-031 Reset asserted mid-BUSY or in DONE SHALL abort the operation with no result delivered; the first cycle after release SHALL show in_ready=1.

Verification
REQ-032 WIDTH=16, LATENCY=4: accept a=5, b=3, mode=01 -> c=5 next edge with out_valid=0; c=8 with out_valid=1, ovf=0 exactly 4 edges after accept.
REQ-033 SATURATE=0: a=0x7FFF, b=1, mode=01 -> c=0x8000, ovf=1; with SATURATE=1 the same operation -> c=0x7FFF, ovf=1; a=0x8000, b=1, mode=10, SATURATE=1 -> c=0x8000, ovf=1.
REQ-034 out_ready held 0 for 10 cycles after out_valid -> c, ovf and out_valid stable and in_ready=0; then out_ready=1 with in_valid=1 (a=2, b=7, mode=11) -> same-edge accept, and c=5 four cycles later.
REQ-035 enable=0 for 3 cycles during BUSY -> out_valid appears 3 cycles later than nominal with the correct result.
REQ-036 rst=0 pulsed 2 cycles after accept, asynchronous to clk -> c=0, out_valid=0 immediately; no result delivered; next accept completes normally.
REQ-037 LATENCY=1: continuous in_valid=1 and out_ready=1 -> one result every 2 cycles, in operand order.
